// File: rtl/nes_audio_pkg.sv
// Shared constants and helpers for the NES audio delta-sigma DAC output stage.
package nes_audio_pkg;

  localparam int          MAX_CHANNELS = 8;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Right-shifting Fibonacci form: bits 0,2,3,5 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Drop the fraction bits and clamp to the DAC full-scale code.
  function automatic logic [31:0] sat_shift(input logic [31:0] sum,
                                            input int unsigned frac_w,
                                            input int unsigned dac_w);
    logic [31:0] q;
    logic [31:0] mx;
    q  = sum >> frac_w;
    mx = (32'd1 << dac_w) - 32'd1;
    return (q > mx) ? mx : q;
  endfunction

endpackage

// File: rtl/nes_dsm_chan.sv
// One channel of the first-order error-feedback modulator: holds the active
// sample, the fraction accumulator and the registered DAC code.
module nes_dsm_chan
  import nes_audio_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int DAC_W = 6
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             tick,
  input  logic             mute,
  input  logic             use_pend,
  input  logic             dith,
  input  logic [IN_W-1:0]  pend,
  output logic [DAC_W-1:0] dac
);

  localparam int F  = IN_W - DAC_W;
  localparam int SW = IN_W + 1;

  logic [IN_W-1:0]  active_q, active_d;
  logic [F-1:0]     acc_q, acc_d;
  logic [DAC_W-1:0] dac_q, dac_d;
  logic [IN_W-1:0]  src;
  logic [SW-1:0]    sum;
  logic [DAC_W-1:0] q;

  always_comb begin
    src      = use_pend ? pend : active_q;
    sum      = {1'b0, src} + SW'(acc_q) + SW'(dith);
    q        = DAC_W'(sat_shift(32'(sum), F, DAC_W));
    active_d = active_q;
    acc_d    = acc_q;
    dac_d    = dac_q;
    if (tick) begin
      active_d = src;
      if (mute) begin
        acc_d = '0;
        dac_d = '0;
      end else begin
        // On saturation the carry is simply lost with the upper sum bits.
        acc_d = sum[F-1:0];
        dac_d = q;
      end
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      active_q <= '0;
      acc_q    <= '0;
      dac_q    <= '0;
    end else begin
      active_q <= active_d;
      acc_q    <= acc_d;
      dac_q    <= dac_d;
    end
  end

  assign dac = dac_q;

endmodule

// File: rtl/nes_audio_dac_out.sv
// NES audio output stage: tick divider, one-deep sample buffer with valid/ready,
// and CHANNELS delta-sigma modulators. Define NES_DAC_DITHER_EN for LFSR dither.
module nes_audio_dac_out
  import nes_audio_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 16,
  parameter int DAC_W    = 6,
  parameter int RATE_DIV = 1
) (
  input  logic                      m_clock,
  input  logic                      p_reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic                      mute,
  output logic [CHANNELS*DAC_W-1:0] dac_out,
  output logic                      dac_stb
);

  logic [15:0]              cnt_q, cnt_d;
  logic                     tick;
  logic                     pend_full_q, pend_full_d;
  logic [CHANNELS*IN_W-1:0] pend_q, pend_d;
  logic                     dac_stb_q, dac_stb_d;
  logic                     accept;
  logic [CHANNELS-1:0]      dith;

  assign in_ready = !pend_full_q;
  assign accept   = in_valid && in_ready;
  assign tick     = (cnt_q == 16'(RATE_DIV - 1));

  always_comb begin
    cnt_d       = tick ? 16'd0 : cnt_q + 16'd1;
    pend_d      = accept ? in_data : pend_q;
    // A load can only happen while empty, so it never races a tick-side clear.
    pend_full_d = accept ? 1'b1 : (tick ? 1'b0 : pend_full_q);
    dac_stb_d   = tick;
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      dac_stb_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      dac_stb_q   <= dac_stb_d;
    end
  end

`ifdef NES_DAC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = tick ? lfsr_next(lfsr_q) : lfsr_q;

  always_ff @(posedge m_clock) begin
    if (p_reset) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign dith = lfsr_q[CHANNELS-1:0];
`else
  assign dith = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    nes_dsm_chan #(
      .IN_W (IN_W),
      .DAC_W(DAC_W)
    ) u_chan (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .tick    (tick),
      .mute    (mute),
      .use_pend(pend_full_q),
      .dith    (dith[c]),
      .pend    (pend_q[c*IN_W +: IN_W]),
      .dac     (dac_out[c*DAC_W +: DAC_W])
    );
  end

  assign dac_stb = dac_stb_q;

endmodule

// File: tb/tb_nes_audio_dac_out.sv
// Directed bench: two instances (RATE_DIV 1 and 4), IN_W=8, DAC_W=6, 2 channels.
module tb_nes_audio_dac_out;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        r1, v1, m1, rdy1, s1;
  logic [15:0] d1;
  logic [11:0] o1;
  logic        r4, v4, m4, rdy4, s4;
  logic [15:0] d4;
  logic [11:0] o4;

  int tests = 0;
  int fails = 0;

  nes_audio_dac_out #(.CHANNELS(2), .IN_W(8), .DAC_W(6), .RATE_DIV(1)) dut1 (
    .m_clock(clk), .p_reset(r1), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .mute(m1), .dac_out(o1), .dac_stb(s1)
  );

  nes_audio_dac_out #(.CHANNELS(2), .IN_W(8), .DAC_W(6), .RATE_DIV(4)) dut4 (
    .m_clock(clk), .p_reset(r4), .in_valid(v4), .in_ready(rdy4),
    .in_data(d4), .mute(m4), .dac_out(o4), .dac_stb(s4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  int seq [4] = '{32, 32, 32, 33};

  initial begin
    r1 = 1'b1; v1 = 1'b1; m1 = 1'b0; d1 = 16'h0081;
    r4 = 1'b1; v4 = 1'b0; m4 = 1'b0; d4 = 16'h0000;

    // Reset held 3 cycles while a sample is offered: nothing may load.
    for (int i = 0; i < 3; i++) begin
      tk();
      chk("rst1_rdy", rdy1, 1);
      chk("rst1_dac", o1, 0);
      chk("rst1_stb", s1, 0);
    end
    v1 = 1'b0;
    r1 = 1'b0;

`ifdef NES_DAC_DITHER_EN
    begin
      int sum0;
      int bad;
      tk();
      chk("lfsr_step1", dut1.lfsr_q, 16'h5670);
      d1 = 16'h8080; v1 = 1'b1; tk(); v1 = 1'b0; tk();
      sum0 = 0; bad = 0;
      for (int k = 0; k < 4096; k++) begin
        sum0 += int'(o1[5:0]);
        if (o1[5:0] != 6'd32 && o1[5:0] != 6'd33) bad++;
        tk();
      end
      chk("dith_range", bad, 0);
      // Expected mean is (128 + ~0.5)/4, about 32.125.
      chk("dith_mean", (sum0 >= 32 * 4096) && (sum0 <= 33 * 4096 - 3072), 1);
    end
`else
    // 0x81 on ch0, 0x00 on ch1: accepted and consumed by the next tick.
    d1 = 16'h0081; v1 = 1'b1; tk(); v1 = 1'b0;
    chk("acc_rdy_low", rdy1, 0);
    tk();
    chk("first_stb", s1, 1);
    chk("first_rdy", rdy1, 1);
    for (int k = 0; k < 8; k++) begin
      chk("seq81_ch0", o1[5:0], seq[k % 4]);
      chk("seq81_ch1", o1[11:6], 0);
      tk();
    end

    // Full-scale input must clamp at 63, never wrap.
    d1 = 16'h00FF; v1 = 1'b1; tk(); v1 = 1'b0; tk();
    for (int k = 0; k < 8; k++) begin
      chk("sat_ch0", o1[5:0], 63);
      chk("sat_ch1", o1[11:6], 0);
      tk();
    end

    // Mute over one tick zeroes output and accumulator.
    d1 = 16'h0081; v1 = 1'b1; tk(); v1 = 1'b0; tk();
    m1 = 1'b1; tk();
    chk("mute_ch0", o1[5:0], 0);
    chk("mute_stb", s1, 1);
    m1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tk();
      chk("unmute_seq", o1[5:0], seq[k % 4]);
    end

    // RATE_DIV=4 handshake: A={0x40,0x81}, then B={0x00,0xFF} held behind it.
    d4 = 16'h4081; v4 = 1'b1; r4 = 1'b0;
    tk();                                   // A accepted
    chk("hs_rdy_e1", rdy4, 0);
    d4 = 16'h00FF;
    tk(); chk("hs_rdy_e2", rdy4, 0);
    tk(); chk("hs_rdy_e3", rdy4, 0); chk("hs_stb_e3", s4, 0);
    tk();                                   // tick edge: A transferred
    chk("hs_rdy_e4", rdy4, 1);
    chk("hs_stb_e4", s4, 1);
    chk("hs_a_ch0", o4[5:0], 32);
    chk("hs_a_ch1", o4[11:6], 16);
    tk();                                   // B accepted
    v4 = 1'b0;
    chk("hs_rdy_e5", rdy4, 0);
    for (int k = 5; k < 8; k++) begin
      chk("hs_a_hold", o4[5:0], 32);
      chk("hs_stb_lo", s4, 0);
      tk();
    end
    chk("hs_stb_e8", s4, 1);
    chk("hs_b_ch0", o4[5:0], 63);
    chk("hs_b_ch1", o4[11:6], 0);

    // Reset mid-operation with a sample waiting in the pending buffer.
    d4 = 16'h8080; v4 = 1'b1; tk(); v4 = 1'b0;
    chk("rst4_pend", rdy4, 0);
    r4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tk();
      chk("rst4_rdy", rdy4, 1);
      chk("rst4_dac", o4, 0);
      chk("rst4_stb", s4, 0);
    end
    r4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tk();
      chk("rst4_lost", o4, 0);
      chk("rst4_tick", s4, (k % 4) == 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
